// File: rtl/duc_tx.sv
// duc_tx: digital up-converter, transmit side.
// Mixes I/Q symbols with a writable cos/sin carrier table into one real
// 16-bit passband sample per accepted beat through a 3-stage pipeline.
// Build option: define DUC_SAT_EN to saturate the output to [-32768, 32767];
// without it the output is the low 16 bits of the shifted sum (wraps).
module duc_tx #(
    parameter int TBL_DEPTH = 680,
    parameter int OUT_SHIFT = 3
) (
    input  logic        aclk,
    input  logic        reset,
    input  logic        s_axis_data_tvalid,
    output logic        s_axis_data_tready,
    input  logic        s_axis_data_tlast,
    input  logic [7:0]  s_axis_data_tdata_I,
    input  logic [7:0]  s_axis_data_tdata_Q,
    input  logic        tbl_wr_en,
    input  logic [9:0]  tbl_wr_addr,
    input  logic [15:0] tbl_wr_cos,
    input  logic [15:0] tbl_wr_sin,
    output logic        m_axis_data_tvalid_duc,
    input  logic        m_axis_data_tready_duc,
    output logic        m_axis_data_tlast_duc,
    output logic [15:0] m_axis_data_tdata_duc
);

    localparam logic [10:0] DEPTH_L  = 11'(TBL_DEPTH);
    localparam logic [9:0]  LAST_IDX = 10'(TBL_DEPTH - 1);

    // carrier table, never reset
    logic signed [15:0] r_cos_mem [0:TBL_DEPTH-1];
    logic signed [15:0] r_sin_mem [0:TBL_DEPTH-1];

    logic               w_advance;
    logic               w_accept;
    logic               w_wr_ok;

    logic [9:0]         r_idx;

    // stage 0: accepted symbols and table read
    logic               r_s0_valid;
    logic               r_s0_last;
    logic signed [7:0]  r_s0_i;
    logic signed [7:0]  r_s0_q;
    logic signed [15:0] r_s0_cos;
    logic signed [15:0] r_s0_sin;

    // stage 1: products
    logic               r_s1_valid;
    logic               r_s1_last;
    logic signed [23:0] r_s1_pi;
    logic signed [23:0] r_s1_pq;

    // stage 2: output register
    logic               r_out_valid;
    logic               r_out_last;
    logic [15:0]        r_out_data;

    logic signed [24:0] w_sum;
    logic [15:0]        w_out;

    // whole pipeline moves together whenever the output slot can take a sample
    assign w_advance = !r_out_valid || m_axis_data_tready_duc;
    assign w_accept  = w_advance && s_axis_data_tvalid;
    assign w_wr_ok   = tbl_wr_en && ({1'b0, tbl_wr_addr} < DEPTH_L);

    assign s_axis_data_tready     = w_advance;
    assign m_axis_data_tvalid_duc = r_out_valid;
    assign m_axis_data_tlast_duc  = r_out_last;
    assign m_axis_data_tdata_duc  = r_out_data;

    // table write port; out-of-range addresses are dropped
    always_ff @(posedge aclk) begin
        if (w_wr_ok) begin
            r_cos_mem[tbl_wr_addr] <= tbl_wr_cos;
            r_sin_mem[tbl_wr_addr] <= tbl_wr_sin;
        end
    end

    // mixer sum and output reduction
    always_comb begin
        w_sum = {r_s1_pi[23], r_s1_pi} - {r_s1_pq[23], r_s1_pq};
`ifdef DUC_SAT_EN
        begin
            logic signed [24:0] w_shift;
            w_shift = w_sum >>> OUT_SHIFT;
            if (w_shift > 25'sd32767)
                w_out = 16'h7FFF;
            else if (w_shift < -25'sd32768)
                w_out = 16'h8000;
            else
                w_out = w_shift[15:0];
        end
`else
        w_out = 16'(w_sum >>> OUT_SHIFT);
`endif
    end

    // phase index, symbol/table stage, product stage and output stage
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_idx       <= '0;
            r_s0_valid  <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else if (w_advance) begin
            if (w_accept) begin
                r_idx <= (s_axis_data_tlast || r_idx == LAST_IDX) ? '0 : r_idx + 10'd1;
            end

            // read-before-write: a same-edge table write is not seen here
            r_s0_valid <= s_axis_data_tvalid;
            r_s0_last  <= s_axis_data_tlast;
            r_s0_i     <= s_axis_data_tdata_I;
            r_s0_q     <= s_axis_data_tdata_Q;
            r_s0_cos   <= r_cos_mem[r_idx];
            r_s0_sin   <= r_sin_mem[r_idx];

            r_s1_valid <= r_s0_valid;
            r_s1_last  <= r_s0_last;
            r_s1_pi    <= r_s0_i * r_s0_cos;
            r_s1_pq    <= r_s0_q * r_s0_sin;

            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_last <= r_s1_last;
                r_out_data <= w_out;
            end
        end
    end

endmodule

// File: tb/tb_duc_tx.sv
// tb_duc_tx: self-checking bench for duc_tx.
// A beat-level model (phase counter, table copy, integer mixer) predicts each
// output sample at acceptance time; a monitor compares every handshaken output
// against it, plus directed literal checks on known table/symbol settings.
// Define DUC_SAT_EN for both bench and design to check the saturating build.
module tb_duc_tx;

    localparam int DEPTH = 680;
    localparam int SH    = 3;

    logic        aclk = 1'b0;
    logic        reset;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_last;
    logic [7:0]  s_I;
    logic [7:0]  s_Q;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [15:0] wr_cos;
    logic [15:0] wr_sin;
    logic        m_valid;
    logic        m_tready;
    logic        m_last;
    logic [15:0] m_data;

    duc_tx #(.TBL_DEPTH(DEPTH), .OUT_SHIFT(SH)) dut (
        .aclk                   (aclk),
        .reset                  (reset),
        .s_axis_data_tvalid     (s_tvalid),
        .s_axis_data_tready     (s_tready),
        .s_axis_data_tlast      (s_last),
        .s_axis_data_tdata_I    (s_I),
        .s_axis_data_tdata_Q    (s_Q),
        .tbl_wr_en              (wr_en),
        .tbl_wr_addr            (wr_addr),
        .tbl_wr_cos             (wr_cos),
        .tbl_wr_sin             (wr_sin),
        .m_axis_data_tvalid_duc (m_valid),
        .m_axis_data_tready_duc (m_tready),
        .m_axis_data_tlast_duc  (m_last),
        .m_axis_data_tdata_duc  (m_data)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int d;
        int l;
    } exp_t;

    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    int   cos_m [DEPTH];
    int   sin_m [DEPTH];
    int   idx_m   = 0;
    exp_t exp_q [$];
    int   out_log [$];
    int   last_log [$];
    int   held    = 0;
    int   held_d  = 0;
    int   held_l  = 0;
    int   first_acc = -1;
    int   first_val = -1;
    logic [7:0] fix_I = 8'd0;
    logic [7:0] fix_Q = 8'd0;

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // y = I*cos - Q*sin, arithmetic shift, then saturate or wrap to 16 bits
    function automatic int mix_model(input int iv, input int qv, input int c, input int s);
        int sum;
        int sh;
        sum = iv * c - qv * s;
        sh  = sum >>> SH;
`ifdef DUC_SAT_EN
        if (sh > 32767) sh = 32767;
        else if (sh < -32768) sh = -32768;
`else
        sh = sh & 32'hFFFF;
        if (sh >= 32768) sh = sh - 65536;
`endif
        return sh;
    endfunction

    function automatic int log_at(input int j);
        if (j < out_log.size()) return out_log[j];
        return -99999;
    endfunction

    function automatic int last_at(input int j);
        if (j < last_log.size()) return last_log[j];
        return -1;
    endfunction

    always @(posedge aclk) cyc <= cyc + 1;

    // monitor: model update and output comparison, sampled mid-cycle
    always @(negedge aclk) begin
        exp_t e;
        if (reset) begin
            exp_q.delete();
            idx_m = 0;
            held  = 0;
        end else begin
            chk("tready_eq_advance", int'(s_tready), int'(!m_valid || m_tready));
            if (m_valid && first_val < 0) first_val = cyc;
            if (m_valid) begin
                if (held != 0) begin
                    chk("hold_data", int'($signed(m_data)), held_d);
                    chk("hold_last", int'(m_last), held_l);
                end
                if (m_tready) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL spurious_output: got sample %0d, expected no output", $signed(m_data));
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", int'($signed(m_data)), e.d);
                        chk("out_last", int'(m_last), e.l);
                    end
                    out_log.push_back(int'($signed(m_data)));
                    last_log.push_back(int'(m_last));
                    held = 0;
                end else begin
                    held   = 1;
                    held_d = int'($signed(m_data));
                    held_l = int'(m_last);
                end
            end else begin
                held = 0;
            end
            if (s_tvalid && s_tready) begin
                if (first_acc < 0) first_acc = cyc + 1;
                e.d = mix_model(int'($signed(s_I)), int'($signed(s_Q)), cos_m[idx_m], sin_m[idx_m]);
                e.l = int'(s_last);
                exp_q.push_back(e);
                idx_m = (s_last || idx_m == DEPTH - 1) ? 0 : idx_m + 1;
            end
        end
        // table writes land after this edge's read
        if (wr_en && int'(wr_addr) < DEPTH) begin
            cos_m[wr_addr] = int'($signed(wr_cos));
            sin_m[wr_addr] = int'($signed(wr_sin));
        end
    end

    task automatic reset_dut(input int n);
        s_tvalid = 1'b0;
        wr_en    = 1'b0;
        reset    = 1'b1;
        repeat (n) @(posedge aclk);
        #1;
        reset = 1'b0;
        chk("rst_valid", int'(m_valid), 0);
        chk("rst_last", int'(m_last), 0);
        chk("rst_data", int'(m_data), 0);
        chk("rst_tready", int'(s_tready), 1);
    endtask

    // mode 0: 16384/0, 1: 0/16384, 2: 32767/-32768, 3: k/0, 4: random
    task automatic fill(input int mode);
        s_tvalid = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            wr_en   = 1'b1;
            wr_addr = 10'(k);
            case (mode)
                0: begin wr_cos = 16'd16384; wr_sin = 16'd0; end
                1: begin wr_cos = 16'd0; wr_sin = 16'd16384; end
                2: begin wr_cos = 16'h7FFF; wr_sin = 16'h8000; end
                3: begin wr_cos = 16'(k); wr_sin = 16'd0; end
                default: begin wr_cos = 16'($urandom); wr_sin = 16'($urandom); end
            endcase
            @(posedge aclk);
            #1;
        end
        wr_en = 1'b0;
    endtask

    // rnd=0: fixed fix_I/fix_Q, tlast only on beat last_idx; rnd=1: random symbols and tlast
    task automatic stream(input int n, input int rnd, input int last_idx,
                          input int vprob, input int rprob, input int wprob);
        int sent;
        int guard;
        logic acc;
        sent  = 0;
        guard = 0;
        while (sent < n && guard < n * 60 + 100) begin
            s_tvalid = ($urandom_range(99) < 32'(vprob));
            m_tready = ($urandom_range(99) < 32'(rprob));
            if (rnd != 0) begin
                s_I    = 8'($urandom);
                s_Q    = 8'($urandom);
                s_last = ($urandom_range(15) == 0);
            end else begin
                s_I    = fix_I;
                s_Q    = fix_Q;
                s_last = (sent == last_idx);
            end
            wr_en   = ($urandom_range(99) < 32'(wprob));
            wr_addr = 10'($urandom);
            wr_cos  = 16'($urandom);
            wr_sin  = 16'($urandom);
            @(negedge aclk);
            acc = s_tvalid && s_tready;
            @(posedge aclk);
            #1;
            if (acc) sent++;
            guard++;
        end
        if (sent < n) begin
            n_total++;
            $display("FAIL stream_timeout: got %0d beats accepted, expected %0d", sent, n);
        end
        s_tvalid = 1'b0;
        s_last   = 1'b0;
        wr_en    = 1'b0;
    endtask

    task automatic drain();
        int c;
        c        = 0;
        m_tready = 1'b1;
        s_tvalid = 1'b0;
        while ((exp_q.size() > 0 || m_valid) && c < 50) begin
            @(posedge aclk);
            #1;
            c++;
        end
        if (c >= 50) begin
            n_total++;
            $display("FAIL drain_timeout: got %0d pending samples, expected 0", exp_q.size());
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp16;
        int bad;
        int sent;
        logic acc;
        reset    = 1'b1;
        s_tvalid = 1'b0;
        s_last   = 1'b0;
        s_I      = '0;
        s_Q      = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_cos   = '0;
        wr_sin   = '0;
        m_tready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            cos_m[k] = 0;
            sin_m[k] = 0;
        end
        @(posedge aclk);
        #1;
        reset_dut(3);

        // constant carrier, I=7: every sample 14336, two edges of latency
        fill(0);
        out_log.delete(); last_log.delete();
        first_acc = -1; first_val = -1;
        fix_I = 8'd7; fix_Q = 8'd0;
        stream(20, 0, -1, 100, 100, 0);
        drain();
        chk("t14_latency_edges", first_val - first_acc, 2);
        chk("t14_count", out_log.size(), 20);
        chk("t14_first", log_at(0), 14336);
        chk("t14_last", log_at(19), 14336);

        // sine-only carrier, Q=3: -6144
        fill(1);
        out_log.delete(); last_log.delete();
        fix_I = 8'd0; fix_Q = 8'd3;
        stream(8, 0, 7, 100, 100, 0);
        drain();
        chk("t15_out", log_at(0), -6144);

        // full-scale corner: sum 8322945
        fill(2);
        out_log.delete(); last_log.delete();
        fix_I = 8'd127; fix_Q = 8'd127;
        stream(4, 0, 3, 100, 100, 0);
        drain();
`ifdef DUC_SAT_EN
        exp16 = 32767;
`else
        exp16 = -8208;
`endif
        chk("t16_out", log_at(0), exp16);
        chk("t16_model", mix_model(127, 127, 32767, -32768), exp16);

        // ramp carrier, I=8: output equals phase index
        fill(3);
        reset_dut(1);
        out_log.delete(); last_log.delete();
        fix_I = 8'd8; fix_Q = 8'd0;
        stream(681, 0, -1, 100, 100, 0);
        drain();
        chk("t17_count", out_log.size(), 681);
        chk("t17_first", log_at(0), 0);
        chk("t17_679", log_at(679), 679);
        chk("t17_wrap", log_at(680), 0);

        reset_dut(1);
        out_log.delete(); last_log.delete();
        stream(10, 0, 5, 100, 100, 0);
        drain();
        chk("t17_b5", log_at(5), 5);
        chk("t17_b5_last", last_at(5), 1);
        chk("t17_b6_restart", log_at(6), 0);
        chk("t17_b7", log_at(7), 1);

        // 10-cycle downstream stall with continuous input
        reset_dut(1);
        out_log.delete(); last_log.delete();
        sent = 0;
        for (int c = 0; c < 200 && (sent < 30 || exp_q.size() > 0 || m_valid); c++) begin
            s_tvalid = (sent < 30);
            s_I      = 8'd8;
            s_Q      = 8'd0;
            s_last   = 1'b0;
            m_tready = !(c >= 6 && c < 16);
            @(negedge aclk);
            if (!m_tready && m_valid) chk("t18_tready_low", int'(s_tready), 0);
            acc = s_tvalid && s_tready;
            @(posedge aclk);
            #1;
            if (acc) sent++;
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        chk("t18_count", out_log.size(), 30);
        bad = 0;
        for (int j = 0; j < 30; j++) if (log_at(j) != j) bad++;
        chk("t18_seq_mismatches", bad, 0);

        // reset mid-frame: in-flight beats dropped, index restarts, table kept
        reset_dut(1);
        fix_I = 8'd8; fix_Q = 8'd0;
        stream(6, 0, -1, 100, 100, 0);
        reset = 1'b1;
        @(posedge aclk);
        #1;
        reset = 1'b0;
        chk("t19_valid_after_rst", int'(m_valid), 0);
        out_log.delete(); last_log.delete();
        stream(3, 0, -1, 100, 100, 0);
        drain();
        chk("t19_count", out_log.size(), 3);
        chk("t19_b0", log_at(0), 0);
        chk("t19_b1", log_at(1), 1);
        chk("t19_b2", log_at(2), 2);

        // randomized symbols, tlast, handshakes and in-flight table writes
        fill(4);
        stream(400, 1, -1, 100, 100, 10);
        stream(400, 1, -1, 50, 100, 10);
        stream(400, 1, -1, 100, 50, 10);
        stream(300, 1, -1, 30, 30, 10);
        stream(300, 1, -1, 80, 20, 10);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/duc_tx.md
DUC_TX -- requirements
Module: duc_tx

Interface
REQ-001 The block SHALL have these parameters:
- TBL_DEPTH, default 680: carrier table length in samples.
- OUT_SHIFT, default 3: arithmetic right shift applied to the mixer sum.
REQ-002 The block SHALL have these ports:
- aclk  in  1  sole clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- s_axis_data_tvalid  in  1  input symbol beat valid.
- s_axis_data_tready  out  1  input beat accepted when high with tvalid.
- s_axis_data_tlast  in  1  last symbol of frame.
- s_axis_data_tdata_I  in  8  signed I symbol (nominal ±1,±3,±5,±7).
- s_axis_data_tdata_Q  in  8  signed Q symbol.
- tbl_wr_en  in  1  carrier table write strobe.
- tbl_wr_addr  in  10  table index, 0..TBL_DEPTH-1.
- tbl_wr_cos  in  16  signed cosine sample.
- tbl_wr_sin  in  16  signed sine sample.
- m_axis_data_tvalid_duc  out  1  output sample valid.
- m_axis_data_tready_duc  in  1  downstream ready.
- m_axis_data_tlast_duc  out  1  tlast of the corresponding input beat.
- m_axis_data_tdata_duc  out  16  signed real passband sample.

Function
REQ-003 Carrier table: dual arrays cos[0..TBL_DEPTH-1], sin[0..TBL_DEPTH-1], written on any edge with tbl_wr_en=1; writes with tbl_wr_addr>=TBL_DEPTH SHALL be ignored.
REQ-004 The table read SHALL be synchronous; a write and a read of the same address on one edge SHALL return the old value.
REQ-005 Phase index: increments by 1 per accepted beat and wraps TBL_DEPTH-1 -> 0; after an accepted beat with tlast=1 the next beat SHALL use index 0.
REQ-006 Mixer: y = I*cos[idx] - Q*sin[idx], computed with 24-bit products and a 25-bit signed sum; out = sum >>> OUT_SHIFT, reduced to 16 bits per REQ-013.
REQ-007 Pipeline stages:
- Edge E: beat accepted; symbols, tlast and table read registered.
- Edge E+1: products registered.
- Edge E+2: output register loaded; m_axis_data_tvalid_duc high.
REQ-008 Global advance = !m_axis_data_tvalid_duc || m_axis_data_tready_duc; all stages and the phase index SHALL hold when advance=0.
REQ-009 s_axis_data_tready SHALL equal advance; this combinational path from m_axis_data_tready_duc is intentional.
REQ-010 Bubbles SHALL propagate as invalid stages; no beat may be dropped or duplicated under any tvalid/tready pattern.
REQ-011 m_axis_data_tdata_duc and m_axis_data_tlast_duc SHALL stay stable while m_axis_data_tvalid_duc=1 and m_axis_data_tready_duc=0.

Reset
REQ-012 On reset=1 at an edge, the block SHALL:
- clear all stage valids, the phase index, and m_axis_data_tvalid_duc/tlast_duc/tdata_duc to 0;
- keep table contents unchanged;
- drive s_axis_data_tready=1 on the cycle after reset deasserts;
- discard in-flight beats when reset arrives mid-frame.

Configuration
REQ-013 With macro DUC_SAT_EN defined, out SHALL saturate to [-32768, 32767]; without it, out SHALL be the low 16 bits of sum >>> OUT_SHIFT (two's-complement wrap).

Verification
REQ-014 cos[k]=16384, sin[k]=0 for all k; I=7, Q=0 continuous, ready=1 -> every output 14336; first m_axis_data_tvalid_duc 2 edges after the first acceptance edge.
REQ-015 cos=0, sin=16384; I=0, Q=3 -> output -6144.
REQ-016 cos=32767, sin=-32768; I=127, Q=127 -> sum 8322945; output 32767 with DUC_SAT_EN, -8208 without.
REQ-017 cos[k]=k, sin=0, I=8 -> outputs are k:
- 681 beats without tlast: outputs 0..679 then 0.
- tlast on beat 5: beat 6 outputs 0.
REQ-018 m_axis_data_tready_duc low for 10 cycles with s_axis_data_tvalid high -> s_axis_data_tready low while the output is held; after release, output sequence is identical to the no-stall run, with no loss or duplication.
REQ-019 reset pulsed mid-frame -> m_axis_data_tvalid_duc 0 the next cycle; the first beat after reset uses index 0; table contents are preserved.
